hour_chime_ctrl: RTL and testbench

//  Upstream driver of the beep-count stage: watches the running time of day and requests an hourly chime.
//  At hh:00:00 it drives a beep count (1..12, 12-hour mapped) and holds a level enable long enough for every beep.

---
 rtl/hour_chime_ctrl_pkg.sv | 15 +
 rtl/hour_chime_ctrl_bcd_hour_to_12h.sv | 31 +++
 rtl/hour_chime_ctrl.sv | 103 ++++++++++
 tb/tb_hour_chime_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/hour_chime_ctrl_pkg.sv
// Shared definitions for the hourly chime controller: FSM encoding and BCD time constants.
package hour_chime_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RING = 2'd2,
        GAP  = 2'd3
    } state_t;

    localparam logic [7:0] BCD_ZERO     = 8'h00;
    localparam logic [7:0] BCD_THIRTY   = 8'h30;
    localparam logic [7:0] MAX_HOUR_BCD = 8'h23;

endpackage

// File: rtl/hour_chime_ctrl_bcd_hour_to_12h.sv
// Combinational BCD hour (00..23) to 12-hour beep count (1..12); valid flags malformed BCD or hour > 23.
module bcd_hour_to_12h
    import hour_chime_ctrl_pkg::*;
(
    input  logic [7:0] hour_bcd,
    output logic [4:0] count,
    output logic       valid
);

    logic [3:0] tens;
    logic [3:0] ones;
    logic [4:0] bin;

    always_comb begin
        tens  = hour_bcd[7:4];
        ones  = hour_bcd[3:0];
        valid = (tens <= 4'd2) && (ones <= 4'd9) && (hour_bcd <= MAX_HOUR_BCD);
        bin   = 5'({3'b000, tens[1:0]} * 5'd10) + {1'b0, ones};
        count = 5'd0;
        // Midnight and noon both ring twelve times; afternoon hours fold down by twelve.
        if (valid) begin
            if (bin == 5'd0)
                count = 5'd12;
            else if (bin > 5'd12)
                count = bin - 5'd12;
            else
                count = bin;
        end
    end

endmodule

// File: rtl/hour_chime_ctrl.sv
// Hourly chime requester: IDLE->LOAD->RING->GAP sequencer driving beep count and level enable.
// Optional build macro HALF_HOUR_CHIME_EN adds a single-beep chime at mm:ss == 30:00.
module hour_chime_ctrl
    import hour_chime_ctrl_pkg::*;
#(
    parameter int BEEP_TICKS  = 1,
    parameter int GUARD_TICKS = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sec_tick,
    input  logic [7:0] hour_bcd,
    input  logic [7:0] min_bcd,
    input  logic [7:0] sec_bcd,
    input  logic       chime_on,
    input  logic       setting,
    output logic [4:0] chime_count,
    output logic       chime_en,
    output logic       busy
);

    state_t     state;
    logic [7:0] tick_cnt;
    logic [4:0] pend_cnt;
    logic [4:0] map_cnt;
    logic       hour_ok;
    logic       hit_top;
    logic       hit_half;
    logic       trigger;
    logic       abort;
    logic [7:0] load_ticks;

    bcd_hour_to_12h u_map (
        .hour_bcd (hour_bcd),
        .count    (map_cnt),
        .valid    (hour_ok)
    );

    assign hit_top = (min_bcd == BCD_ZERO) && (sec_bcd == BCD_ZERO);
`ifdef HALF_HOUR_CHIME_EN
    assign hit_half = (min_bcd == BCD_THIRTY) && (sec_bcd == BCD_ZERO);
`else
    assign hit_half = 1'b0;
`endif

    assign trigger    = sec_tick && chime_on && !setting && hour_ok && (hit_top || hit_half);
    assign abort      = setting || !chime_on;
    assign load_ticks = 8'(int'(pend_cnt) * BEEP_TICKS + GUARD_TICKS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            tick_cnt    <= 8'd0;
            pend_cnt    <= 5'd0;
            chime_count <= 5'd0;
            chime_en    <= 1'b0;
            busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (trigger) begin
                        // Count is latched here so LOAD sees the hour that caused the trigger.
                        pend_cnt <= hit_top ? map_cnt : 5'd1;
                        state    <= LOAD;
                        busy     <= 1'b1;
                    end
                end
                LOAD: begin
                    if (abort) begin
                        state <= GAP;
                    end else begin
                        chime_count <= pend_cnt;
                        tick_cnt    <= load_ticks;
                        chime_en    <= 1'b1;
                        state       <= RING;
                    end
                end
                RING: begin
                    // Abort wins over expiry; both end in GAP with the enable dropped.
                    if (abort || (sec_tick && tick_cnt == 8'd1)) begin
                        chime_en <= 1'b0;
                        tick_cnt <= 8'd0;
                        state    <= GAP;
                    end else if (sec_tick) begin
                        tick_cnt <= tick_cnt - 8'd1;
                    end
                end
                GAP: begin
                    if (sec_tick) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    chime_en <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hour_chime_ctrl.sv
// Self-checking bench for hour_chime_ctrl: vector table, hand corner sequences, randomized model check.
module tb_hour_chime_ctrl;

    localparam int BEEP  = 1;
    localparam int GUARD = 2;
`ifdef HALF_HOUR_CHIME_EN
    localparam bit HALF = 1'b1;
`else
    localparam bit HALF = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sec_tick = 1'b0;
    logic [7:0] hour_bcd = 8'h00;
    logic [7:0] min_bcd = 8'h00;
    logic [7:0] sec_bcd = 8'h01;
    logic       chime_on = 1'b0;
    logic       setting = 1'b0;
    logic [4:0] chime_count;
    logic       chime_en;
    logic       busy;

    int total = 0;
    int bad   = 0;

    hour_chime_ctrl #(.BEEP_TICKS(BEEP), .GUARD_TICKS(GUARD)) dut (
        .clk         (clk),
        .rst         (rst),
        .sec_tick    (sec_tick),
        .hour_bcd    (hour_bcd),
        .min_bcd     (min_bcd),
        .sec_bcd     (sec_bcd),
        .chime_on    (chime_on),
        .setting     (setting),
        .chime_count (chime_count),
        .chime_en    (chime_en),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] h;
        logic [7:0] m;
        logic [7:0] s;
        logic       on;
        logic       set;
        logic       fire;
        logic [4:0] cnt;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic tk);
        sec_tick = tk;
        @(posedge clk);
        #1;
        sec_tick = 1'b0;
    endtask

    // Reference: decode BCD as an integer hour, fold 0..23 onto 1..12.
    function automatic void model(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s,
                                  input logic on, input logic set,
                                  output int fire, output int cnt);
        int hv;
        bit ok;
        bit top;
        bit half;
        hv   = int'(h[7:4]) * 10 + int'(h[3:0]);
        ok   = (h[7:4] <= 4'd9) && (h[3:0] <= 4'd9) && (hv <= 23);
        top  = (m == 8'h00) && (s == 8'h00);
        half = HALF && (m == 8'h30) && (s == 8'h00);
        fire = (on && !set && ok && (top || half)) ? 1 : 0;
        cnt  = top ? ((hv + 11) % 12) + 1 : 1;
    endfunction

    // Fires one tick at the given time, then runs 18 seconds with the clock moved off the trigger
    // time, except at second index retrig where the top-of-hour time is re-presented.
    task automatic run_chime(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s,
                             input logic on, input logic set, input int retrig,
                             output int fired, output int cnt, output int en_ticks, output int stable);
        fired = 0; cnt = 0; en_ticks = 0; stable = 1;
        hour_bcd = h; min_bcd = m; sec_bcd = s; chime_on = on; setting = set;
        step(1'b1);
        sec_bcd = 8'h01;
        for (int sidx = 0; sidx < 18; sidx++) begin
            for (int c = 0; c < 4; c++) begin
                if (busy) fired = 1;
                if (chime_en) begin
                    if (cnt == 0) cnt = int'(chime_count);
                    else if (int'(chime_count) != cnt) stable = 0;
                end
                if (c == 3) begin
                    if (chime_en) en_ticks++;
                    if (retrig > 0 && sidx == retrig) sec_bcd = 8'h00;
                    step(1'b1);
                    sec_bcd = 8'h01;
                end else begin
                    step(1'b0);
                end
            end
        end
    endtask

    task automatic check_run(input string tag, input int exp_fire, input int exp_cnt,
                             input int fired, input int cnt, input int en_ticks, input int stable);
        check({tag, " fired"}, fired, exp_fire);
        if (exp_fire != 0) begin
            check({tag, " count"}, cnt, exp_cnt);
            check({tag, " en_ticks"}, en_ticks, exp_cnt * BEEP + GUARD);
            check({tag, " count_stable"}, stable, 1);
        end else begin
            check({tag, " en_ticks"}, en_ticks, 0);
        end
        check({tag, " busy_end"}, int'(busy), 0);
    endtask

    initial begin
        int fired, cnt, en_ticks, stable, efire, ecnt, hv, r;
        logic [7:0] h, m, s;
        logic on, set;
        bit saw_busy;

        vecs[0]  = '{8'h15, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 5'd3};
        vecs[1]  = '{8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 5'd12};
        vecs[2]  = '{8'h12, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 5'd12};
        vecs[3]  = '{8'h13, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 5'd1};
        vecs[4]  = '{8'h1A, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 5'd0};
        vecs[5]  = '{8'h10, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 5'd0};
        vecs[6]  = '{8'h07, 8'h30, 8'h00, 1'b1, 1'b0, HALF, HALF ? 5'd1 : 5'd0};
        vecs[7]  = '{8'h23, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 5'd11};
        vecs[8]  = '{8'h24, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 5'd0};
        vecs[9]  = '{8'h01, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 5'd1};
        vecs[10] = '{8'h09, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 5'd0};
        vecs[11] = '{8'h12, 8'h00, 8'h01, 1'b1, 1'b0, 1'b0, 5'd0};
        vecs[12] = '{8'h11, 8'h59, 8'h00, 1'b1, 1'b0, 1'b0, 5'd0};

        repeat (3) @(posedge clk);
        #1;
        check("reset chime_en", int'(chime_en), 0);
        check("reset chime_count", int'(chime_count), 0);
        check("reset busy", int'(busy), 0);
        rst = 1'b0;
        step(1'b0);

        for (int i = 0; i < 13; i++) begin
            run_chime(vecs[i].h, vecs[i].m, vecs[i].s, vecs[i].on, vecs[i].set, 0,
                      fired, cnt, en_ticks, stable);
            check_run($sformatf("vec%0d", i), int'(vecs[i].fire), int'(vecs[i].cnt),
                      fired, cnt, en_ticks, stable);
        end

        // Enable latency and abort by setting during RING.
        hour_bcd = 8'h09; min_bcd = 8'h00; sec_bcd = 8'h00; chime_on = 1'b1; setting = 1'b0;
        step(1'b1);
        sec_bcd = 8'h01;
        check("load en_low", int'(chime_en), 0);
        check("load busy", int'(busy), 1);
        step(1'b0);
        check("ring en_high", int'(chime_en), 1);
        check("ring count", int'(chime_count), 9);
        step(1'b0);
        setting = 1'b1;
        step(1'b0);
        check("abort en", int'(chime_en), 0);
        check("abort busy", int'(busy), 1);
        setting = 1'b0;
        step(1'b0);
        step(1'b0);
        check("gap busy", int'(busy), 1);
        check("gap count_held", int'(chime_count), 9);
        step(1'b1);
        check("gap_exit busy", int'(busy), 0);

        // Reset pulse in the middle of a 03:00 chime.
        hour_bcd = 8'h03; min_bcd = 8'h00; sec_bcd = 8'h00;
        step(1'b1);
        sec_bcd = 8'h01;
        step(1'b0);
        step(1'b0);
        step(1'b1);
        #2 rst = 1'b1;
        #1;
        check("midrst chime_en", int'(chime_en), 0);
        check("midrst chime_count", int'(chime_count), 0);
        check("midrst busy", int'(busy), 0);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        saw_busy = 1'b0;
        for (int k = 0; k < 40; k++) begin
            step(k % 4 == 3);
            if (busy || chime_en) saw_busy = 1'b1;
        end
        check("postrst idle", int'(saw_busy), 0);

        // Retrigger at 11:00:00 while RING must be ignored.
        run_chime(8'h11, 8'h00, 8'h00, 1'b1, 1'b0, 3, fired, cnt, en_ticks, stable);
        check_run("retrig", 1, 11, fired, cnt, en_ticks, stable);

        for (int it = 0; it < 25; it++) begin
            r = $urandom_range(0, 9);
            if (r < 8) begin
                hv = $urandom_range(0, 23);
                h = 8'((hv / 10) * 16 + (hv % 10));
            end else begin
                h = 8'($urandom_range(0, 255));
            end
            r = $urandom_range(0, 9);
            if (r < 6) m = 8'h00;
            else if (r < 8) m = 8'h30;
            else begin
                hv = $urandom_range(0, 59);
                m = 8'((hv / 10) * 16 + (hv % 10));
            end
            s = ($urandom_range(0, 9) < 8) ? 8'h00 : 8'h01;
            on  = ($urandom_range(0, 9) != 0);
            set = ($urandom_range(0, 9) == 0);
            model(h, m, s, on, set, efire, ecnt);
            run_chime(h, m, s, on, set, 0, fired, cnt, en_ticks, stable);
            check_run($sformatf("rnd%0d h=%h m=%h s=%h", it, h, m, s), efire, ecnt,
                      fired, cnt, en_ticks, stable);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
